// File: rtl/shot_sequencer.sv
// shot_sequencer: turn-level controller for the 10x10 grid.
// Each turn it accepts one row/col fire request and checks it against the
// BLUE (unshot) bit of the addressed cell. A valid shot produces a one-cycle
// shot pulse, and the hit is counted against the ship id in that cell.
// Sinking a ship produces a one-cycle sunk/halo mask.
// Every turn ends with a one-cycle result strobe.
module shot_sequencer #(
    parameter int NUM_SHIPS  = 5,
    parameter int ID_W       = 3,
    parameter int SHOT_CNT_W = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fire,
    input  logic [3:0]            row,
    input  logic [3:0]            col,
    input  logic [100*ID_W-1:0]   ship_id_flat,
    input  logic [399:0]          cell_state_flat,
    output logic [99:0]           shot,
    output logic [99:0]           ship_sunk,
    output logic                  busy,
    output logic                  result_valid,
    output logic [1:0]            result,
    output logic [ID_W-1:0]       ships_remaining,
    output logic [SHOT_CNT_W-1:0] shots_fired,
    output logic                  game_over
);
    localparam int NUM_CELLS = 100;
    localparam int GRID_DIM  = 10;
    localparam int NUM_IDS   = 1 << ID_W;
    localparam int LEN_W     = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FIRE  = 3'd2,
        EVAL  = 3'd3,
        SINK  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Static 3x3 neighbourhood of cell (r,c). Rows and columns are clipped at
    // the grid edge, so column 9 never wraps to column 0 and row 9 never
    // wraps to row 0.
    function automatic logic [NUM_CELLS-1:0] halo_window(input int r, input int c);
        logic [NUM_CELLS-1:0] w;
        w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((r + dr) >= 0 && (r + dr) < GRID_DIM &&
                    (c + dc) >= 0 && (c + dc) < GRID_DIM) begin
                    w[7'((r + dr) * GRID_DIM + (c + dc))] = 1'b1;
                end
            end
        end
        return w;
    endfunction

    state_t                state_reg;
    state_t                state_next;

    logic [3:0]            row_reg;
    logic [3:0]            col_reg;
    logic [ID_W-1:0]       sink_id_reg;
    logic [1:0]            result_reg;
    logic [ID_W-1:0]       remaining_reg;
    logic [SHOT_CNT_W-1:0] fired_reg;
    logic                  game_over_reg;

    logic [ID_W-1:0]       cell_id [NUM_CELLS];
    logic [NUM_CELLS-1:0]  cell_blue;
    logic [NUM_CELLS-1:0]  sink_member;
    logic [LEN_W-1:0]      ship_len [NUM_IDS];
    logic [LEN_W-1:0]      hit_count [NUM_IDS];

    logic [7:0]            target_idx;
    logic                  target_in_grid;
    logic [6:0]            cell_idx;
    logic [ID_W-1:0]       target_id;
    logic                  target_valid;
    logic                  target_is_ship;
    logic                  last_segment;
    logic                  accept_fire;

    // The target is latched at fire time, so every index below stays
    // constant for the whole turn.
    assign target_idx     = ({4'd0, row_reg} * 8'd10) + {4'd0, col_reg};
    assign target_in_grid = (row_reg <= 4'd9) && (col_reg <= 4'd9);
    assign cell_idx       = target_in_grid ? target_idx[6:0] : 7'd0;
    assign target_id      = cell_id[cell_idx];
    assign target_valid   = target_in_grid && cell_blue[cell_idx];
    // Id 0 is water. Ids above NUM_SHIPS are also treated as water.
    assign target_is_ship = (target_id != '0) && (target_id <= ID_W'(NUM_SHIPS));
    assign last_segment   = (hit_count[target_id] + LEN_W'(1)) == ship_len[target_id];
    assign accept_fire    = fire && !game_over_reg;

    // Per-cell decode: id, BLUE bit, membership in the ship being sunk, and
    // the two output pulses.
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        localparam logic [NUM_CELLS-1:0] HALO = halo_window(gi / GRID_DIM, gi % GRID_DIM);
        logic unused_state_bits;

        assign cell_id[gi]       = ship_id_flat[gi*ID_W +: ID_W];
        assign cell_blue[gi]     = cell_state_flat[gi*4];
        assign unused_state_bits = ^cell_state_flat[gi*4+1 +: 3];
        assign sink_member[gi]   = (cell_id[gi] == sink_id_reg);
        assign shot[gi]          = (state_reg == FIRE) && (target_idx == 8'(gi));
        // A cell is in the sunk mask if any ship cell lies in its clipped
        // 3x3 window. This is the same as taking every ship cell and
        // marking its clipped neighbours.
        assign ship_sunk[gi]     = (state_reg == SINK) && |(sink_member & HALO);
    end

    // Ship lengths come straight from the map. They are counted
    // combinationally, so the same logic works for any layout.
    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_ship
        if (gi >= 1 && gi <= NUM_SHIPS) begin : g_used
            logic [NUM_CELLS-1:0] id_match;
            logic [LEN_W-1:0]     hit_count_reg;

            for (genvar gc = 0; gc < NUM_CELLS; gc++) begin : g_match
                assign id_match[gc] = (cell_id[gc] == ID_W'(gi));
            end
            assign ship_len[gi]  = LEN_W'($countones(id_match));
            assign hit_count[gi] = hit_count_reg;

            // Hit counter for this ship id. It advances once per hit, in EVAL.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hit_count_reg <= '0;
                end else if (state_reg == EVAL && target_is_ship &&
                             target_id == ID_W'(gi)) begin
                    hit_count_reg <= hit_count_reg + LEN_W'(1);
                end
            end
        end else begin : g_unused
            assign ship_len[gi]  = '0;
            assign hit_count[gi] = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for one turn: validate, fire, evaluate, optional sink, report.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_fire) state_next = CHECK;
            CHECK:   state_next = target_valid ? FIRE : DONE;
            FIRE:    state_next = EVAL;
            EVAL:    state_next = (target_is_ship && last_segment) ? SINK : DONE;
            SINK:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Turn datapath: latch the target, and update the result and the shot
    // and ship counters. Each result is written on the edge that enters
    // DONE and is held until the next turn overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_reg       <= '0;
            col_reg       <= '0;
            sink_id_reg   <= '0;
            result_reg    <= 2'b00;
            remaining_reg <= ID_W'(NUM_SHIPS);
            fired_reg     <= '0;
            game_over_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_fire) begin
                        row_reg <= row;
                        col_reg <= col;
                    end
                end
                CHECK: begin
                    if (!target_valid) begin
                        result_reg <= 2'b11;
                    end
                end
                FIRE: begin
                    if (fired_reg != {SHOT_CNT_W{1'b1}}) begin
                        fired_reg <= fired_reg + SHOT_CNT_W'(1);
                    end
                end
                EVAL: begin
                    sink_id_reg <= target_id;
                    if (!target_is_ship) begin
                        result_reg <= 2'b00;
                    end else if (!last_segment) begin
                        result_reg <= 2'b01;
                    end
                end
                SINK: begin
                    result_reg <= 2'b10;
                    if (remaining_reg != '0) begin
                        remaining_reg <= remaining_reg - ID_W'(1);
                    end
                    if (remaining_reg == ID_W'(1)) begin
                        game_over_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state_reg != IDLE);
    assign result_valid    = (state_reg == DONE);
    assign result          = result_reg;
    assign ships_remaining = remaining_reg;
    assign shots_fired     = fired_reg;
    assign game_over       = game_over_reg;

endmodule
